// File: rtl/rx_inst_loader.sv
// UART byte -> instruction loader. Received bytes are queued in a small FIFO and
// issued one at a time as instruction words, with a fixed idle gap after each issue.
module rx_inst_loader #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned GAP_CYCLES = 131072
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    i_rx_data,
  input  logic                          i_rx_valid,
  input  logic                          i_seq_busy,
  input  logic                          i_flush,
  output logic [7:0]                    o_inst,
  output logic                          o_inst_valid,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic                          o_overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(GAP_CYCLES + 1);
  localparam logic [CW-1:0] GapLast = CW'(GAP_CYCLES - 1);
  localparam logic [AW:0]   Depth   = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StIssue, StGap} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   gap_q, gap_d;
  logic [AW:0]     wptr_q, rptr_q, count;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      inst_q, inst_d;
  logic            ovf_q, ovf_d;
  logic            full, empty, push, pop, drop;

  // Pointers carry one extra bit so full and empty differ when the indices match.
  assign count = wptr_q - rptr_q;
  assign full  = (count == Depth);
  assign empty = (count == '0);
  // A same-cycle pop frees a slot, so a byte arriving on a full FIFO is still taken.
  assign push  = i_rx_valid & ~i_flush & (~full | pop);
  assign drop  = i_rx_valid & ~i_flush & full & ~pop;

  // FSM state and gap counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

  // Next-state: issue when work is pending and the sequencer is free, then wait out the gap
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    case (state_q)
      StIdle: begin
        if (!empty && !i_seq_busy) state_d = StIssue;
      end
      StIssue: begin
        state_d = StGap;
        gap_d   = '0;
      end
      StGap: begin
        if (gap_q == GapLast) begin
          state_d = StIdle;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    // Flush wins over everything; a pulse already in ISSUE still goes out this cycle.
    if (i_flush) begin
      state_d = StIdle;
      gap_d   = '0;
    end
  end

  // Outputs: the issue pulse is a decode of the registered state
  always_comb begin
    pop          = (state_q == StIssue);
    o_inst_valid = pop;
    o_inst       = inst_q;
    o_count      = count;
    o_overflow   = ovf_q;
  end

  // Datapath next-state: latch the head word as the FSM heads into ISSUE
  always_comb begin
    inst_d = inst_q;
    if (state_q == StIdle && state_d == StIssue) inst_d = mem_q[rptr_q[AW-1:0]];
    ovf_d = i_flush ? 1'b0 : (ovf_q | drop);
  end

  // FIFO pointers, issued word and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      inst_q <= 8'h00;
      ovf_q  <= 1'b0;
    end else begin
      inst_q <= inst_d;
      ovf_q  <= ovf_d;
      if (i_flush) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (push) wptr_q <= wptr_q + 1'b1;
        if (pop)  rptr_q <= rptr_q + 1'b1;
      end
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= i_rx_data;
  end

endmodule

// File: tb/tb_rx_inst_loader.sv
// Bench for rx_inst_loader: queue-based reference model checked every cycle, plus
// directed scenarios with hand-computed cycle/value expectations.
module tb_rx_inst_loader;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned GAP   = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       busy = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] o_inst;
  logic       o_inst_valid;
  logic [2:0] o_count;
  logic       o_overflow;

  rx_inst_loader #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_rx_data    (rx_data),
    .i_rx_valid   (rx_valid),
    .i_seq_busy   (busy),
    .i_flush      (flush),
    .o_inst       (o_inst),
    .o_inst_valid (o_inst_valid),
    .o_count      (o_count),
    .o_overflow   (o_overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model. Cycle k is the interval after the k-th rising edge.
  // Rules: an issue lands one cycle after an idle cycle with a non-empty queue and busy low;
  // after an issue in cycle c the loader is idle again from cycle c+GAP+1 on.
  int         cyc = 0;
  logic [7:0] q[$];
  logic [7:0] m_inst = 8'h00;
  bit         m_valid = 1'b0;
  bit         m_ovf = 1'b0;
  int         earliest = 0;

  always @(posedge clk) begin
    bit decide;
    logic [7:0] head;
    if (!rst_n) begin
      q.delete();
      m_inst   = 8'h00;
      m_valid  = 1'b0;
      m_ovf    = 1'b0;
      earliest = cyc + 1;
    end else begin
      decide = !flush && (cyc >= earliest) && (q.size() > 0) && !busy;
      head   = (q.size() > 0) ? q[0] : 8'h00;
      if (flush) begin
        q.delete();
        m_ovf    = 1'b0;
        earliest = cyc + 1;
      end else begin
        if (m_valid) void'(q.pop_front());
        if (rx_valid) begin
          if (q.size() < DEPTH) q.push_back(rx_data);
          else m_ovf = 1'b1;
        end
      end
      if (decide) begin
        m_inst   = head;
        earliest = cyc + 2 + GAP;
      end
      m_valid = decide;
    end
    cyc++;
  end

  // Compare process: every cycle, against the model (or reset values while in reset)
  always @(negedge clk) begin
    chk("valid", int'(o_inst_valid), rst_n ? int'(m_valid) : 0);
    chk("inst",  int'(o_inst),       rst_n ? int'(m_inst)  : 0);
    chk("count", int'(o_count),      rst_n ? q.size()      : 0);
    chk("ovf",   int'(o_overflow),   rst_n ? int'(m_ovf)   : 0);
  end

  // Pulse log for the directed scenarios
  int         log_c[$];
  logic [7:0] log_v[$];
  always @(negedge clk) begin
    if (rst_n && o_inst_valid) begin
      log_c.push_back(cyc);
      log_v.push_back(o_inst);
    end
  end

  task automatic clr();
    log_c.delete();
    log_v.delete();
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  int n;

  initial begin
    idle(2);
    chk("rst_inst",  int'(o_inst), 0);
    chk("rst_count", int'(o_count), 0);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Single byte: pulse two cycles after the strobe
    clr();
    n = cyc;
    send(8'hA5);
    chk("t1_cnt_n1", int'(o_count), 1);
    @(negedge clk);
    chk("t1_pulse", int'(o_inst_valid), 1);
    chk("t1_inst",  int'(o_inst), 8'hA5);
    chk("t1_cnt_n2", int'(o_count), 1);
    @(negedge clk);
    chk("t1_cnt_n3", int'(o_count), 0);
    chk("t1_noval", int'(o_inst_valid), 0);
    idle(10);
    chk("t1_npulse", log_c.size(), 1);
    chk("t1_when", (log_c.size() > 0) ? log_c[0] : -1, n + 2);

    // Three back-to-back bytes: pulses GAP+2 apart
    clr();
    n = cyc;
    send(8'h01);
    send(8'h02);
    send(8'h03);
    idle(20);
    chk("t2_npulse", log_c.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk("t2_when", (log_c.size() > i) ? log_c[i] : -1, n + 2 + 6 * i);
      chk("t2_val",  (log_v.size() > i) ? int'(log_v[i]) : -1, 1 + i);
    end

    // Overflow while busy; only the first four bytes are issued
    do_reset();
    clr();
    busy = 1'b1;
    for (int i = 0; i < 6; i++) send(8'h10 + 8'(i));
    chk("t3_count", int'(o_count), 4);
    chk("t3_ovf", int'(o_overflow), 1);
    busy = 1'b0;
    idle(30);
    chk("t3_npulse", log_c.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("t3_val", (log_v.size() > i) ? int'(log_v[i]) : -1, 8'h10 + i);
    chk("t3_ovf_sticky", int'(o_overflow), 1);

    // Full FIFO, byte arriving in the ISSUE cycle is accepted
    do_reset();
    clr();
    busy = 1'b1;
    for (int i = 0; i < 4; i++) send(8'h20 + 8'(i));
    busy = 1'b0;
    @(negedge clk);
    chk("t4_issue", int'(o_inst_valid), 1);
    chk("t4_full", int'(o_count), 4);
    send(8'h77);
    chk("t4_count", int'(o_count), 4);
    chk("t4_ovf", int'(o_overflow), 0);
    idle(40);
    chk("t4_npulse", log_c.size(), 5);
    chk("t4_last", (log_v.size() > 4) ? int'(log_v[4]) : -1, 8'h77);

    // Flush during GAP, with a same-cycle byte that must be dropped silently
    do_reset();
    clr();
    send(8'h31);
    send(8'h32);
    send(8'h33);
    @(negedge clk);
    flush    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h99;
    @(negedge clk);
    flush    = 1'b0;
    rx_valid = 1'b0;
    chk("t5_count", int'(o_count), 0);
    chk("t5_ovf", int'(o_overflow), 0);
    idle(20);
    chk("t5_npulse", log_c.size(), 1);
    chk("t5_val", (log_v.size() > 0) ? int'(log_v[0]) : -1, 8'h31);

    // Reset during GAP with two bytes still queued
    do_reset();
    send(8'h41);
    send(8'h42);
    send(8'h43);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_inst", int'(o_inst), 0);
    chk("t6_count", int'(o_count), 0);
    chk("t6_valid", int'(o_inst_valid), 0);
    chk("t6_ovf", int'(o_overflow), 0);
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    clr();
    idle(20);
    chk("t6_npulse", log_c.size(), 0);
    n = cyc;
    send(8'h55);
    idle(3);
    chk("t6_new", log_c.size(), 1);
    chk("t6_when", (log_c.size() > 0) ? log_c[0] : -1, n + 2);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        rx_valid = 1'b0;
        flush    = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
      end
      rx_valid = ($urandom % 5) < 2;
      rx_data  = 8'($urandom);
      flush    = ($urandom_range(0, 79) == 0);
      if ($urandom % 8 == 0) busy = ~busy;
      @(negedge clk);
    end
    rx_valid = 1'b0;
    flush    = 1'b0;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rx_inst_loader.md
RX_INST_LOADER -- requirements
Module: rx_inst_loader

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set instruction FIFO entries; power of two, >=2.
REQ-002 Parameter GAP_CYCLES, default 131072, SHALL set the minimum idle cycles after each issued instruction; >=1.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  SHALL be the reset: asynchronous assert, active-low.
REQ-005 Port i_rx_data  input  8  SHALL carry a received UART byte, valid only when i_rx_valid=1.
REQ-006 Port i_rx_valid  input  1  SHALL be a one-cycle strobe per received byte.
REQ-007 Port i_seq_busy  input  1  SHALL be high while the sequencer/UART transmitter cannot take an instruction.
REQ-008 Port i_flush  input  1  SHALL be a synchronous request to discard all queued bytes.
REQ-009 Port o_inst  output  8  SHALL carry the instruction word being issued.
REQ-010 Port o_inst_valid  output  1  SHALL be a one-cycle issue pulse for o_inst.
REQ-011 Port o_count  output  log2(FIFO_DEPTH)+1  SHALL report current FIFO occupancy.
REQ-012 Port o_overflow  output  1  SHALL be a sticky flag: a byte was dropped.

Function
REQ-013 Each accepted byte SHALL become one instruction word, unmodified, issued in arrival order.
REQ-014 Push: i_rx_valid=1, i_flush=0, and (count<FIFO_DEPTH or a pop occurs the same cycle) SHALL write the byte.
REQ-015 Push when full with no same-cycle pop SHALL drop the byte, leave the FIFO unchanged, and set o_overflow.
REQ-016 Simultaneous push and pop SHALL leave o_count unchanged, with both operations taking effect.
REQ-017 FSM states SHALL be IDLE, ISSUE, GAP.
REQ-018 IDLE -> ISSUE SHALL occur when count>0 and i_seq_busy=0; otherwise remain in IDLE.
REQ-019 In ISSUE (exactly one cycle): o_inst_valid=1, o_inst=FIFO head, head popped; next state GAP.
REQ-020 GAP SHALL last exactly GAP_CYCLES cycles, ignoring i_seq_busy, then enter IDLE.
REQ-021 o_inst SHALL be registered and hold the last issued value until the next ISSUE.
REQ-022 Latency: byte strobed in cycle N into an empty FIFO, IDLE, busy low SHALL give o_inst_valid in cycle N+2.
REQ-023 Spacing: consecutive o_inst_valid pulses SHALL be at least GAP_CYCLES+2 cycles apart; exactly that when the FIFO is non-empty and busy is low.
REQ-024 i_seq_busy rising in the same cycle IDLE would transition SHALL hold the FSM in IDLE; no pulse.
REQ-025 i_flush=1 SHALL, next cycle: count=0, o_overflow=0, FSM=IDLE, gap counter=0; same-cycle i_rx_valid byte dropped without setting o_overflow.
REQ-026 i_flush asserted in ISSUE SHALL still complete that pulse; the flush takes effect after it.
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full/empty distinguished by the extra pointer bit.
REQ-028 Gap counter SHALL be sized ceil(log2(GAP_CYCLES+1)) bits with no wrap-around.

Reset
REQ-029 rst_n=0 SHALL immediately force: FSM=IDLE, FIFO empty, o_count=0, o_inst=8'h00, o_inst_valid=0, o_overflow=0, gap counter=0.
REQ-030 Reset mid-GAP or mid-ISSUE SHALL abort; bytes queued before reset SHALL never be issued.
REQ-031 The first push SHALL be accepted on the first rising clk edge after rst_n deasserts.

Verification (GAP_CYCLES=4, FIFO_DEPTH=4)
REQ-032 Byte 8'hA5 at cycle 10, busy=0 -> o_inst_valid only at cycle 12, o_inst=8'hA5, o_count 1 then 0.
REQ-033 Bytes 8'h01..8'h03 at cycles 10,11,12 -> pulses at cycles 12,18,24 with 8'h01,8'h02,8'h03 in order.
REQ-034 Busy=1, six bytes 8'h10..8'h15 pushed -> o_count=4, o_overflow=1; busy released -> 8'h10..8'h13 issued only.
REQ-035 FIFO full, byte 8'h77 arrives in the ISSUE cycle -> accepted, o_count stays 4, 8'h77 issued last.
REQ-036 Three bytes queued, i_flush during GAP -> o_count=0, o_overflow=0 next cycle; no further pulses.
REQ-037 rst_n low during GAP with 2 bytes queued -> all outputs at reset values immediately; no pulses after release until a new byte arrives.
